// File: rtl/svc_axi_sram_rd.sv
// AXI4 read-burst front end: expands one AR burst into single-word SRAM read
// commands and passes the SRAM read-response stream straight out as the R channel.
module svc_axi_sram_rd #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - $clog2(AXI_DATA_WIDTH / 8),
    parameter int SRAM_DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int SRAM_STRB_WIDTH = SRAM_DATA_WIDTH / 8,
    parameter int SRAM_META_WIDTH = AXI_ID_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
    input  logic [7:0]                 s_axi_arlen,
    input  logic [2:0]                 s_axi_arsize,
    input  logic [1:0]                 s_axi_arburst,

    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rlast,

    output logic                       sram_cmd_valid,
    input  logic                       sram_cmd_ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
    output logic [SRAM_META_WIDTH-1:0] sram_cmd_meta,
    output logic                       sram_cmd_last,
    output logic                       sram_cmd_wr_en,
    output logic [SRAM_DATA_WIDTH-1:0] sram_cmd_wr_data,
    output logic [SRAM_STRB_WIDTH-1:0] sram_cmd_wr_strb,

    input  logic                       sram_rd_resp_valid,
    output logic                       sram_rd_resp_ready,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_resp_data,
    input  logic [SRAM_META_WIDTH-1:0] sram_rd_resp_meta,
    input  logic                       sram_rd_resp_last
);

    localparam int BYTE_BITS = $clog2(AXI_DATA_WIDTH / 8);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                     state_q, state_d;
    logic                       arready_q, arready_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SRAM_META_WIDTH-1:0] id_q, id_d;
    logic [1:0]                 burst_q, burst_d;
    logic [7:0]                 len_q, len_d;
    logic [7:0]                 rem_q, rem_d;

    logic                       ar_hs;
    logic                       cmd_hs;
    logic [SRAM_ADDR_WIDTH-1:0] addr_inc;
    logic [SRAM_ADDR_WIDTH-1:0] len_mask;
    logic [SRAM_ADDR_WIDTH-1:0] wrap_addr;
    logic                       unused_ok;

    assign ar_hs     = s_axi_arvalid && arready_q;
    assign cmd_hs    = sram_cmd_valid && sram_cmd_ready;
    assign addr_inc  = addr_q + SRAM_ADDR_WIDTH'(1);
    assign len_mask  = SRAM_ADDR_WIDTH'(len_q);
    // WRAP stays inside the (len+1)-word aligned window; len is a power of two minus one.
    assign wrap_addr = (addr_q & ~len_mask) | (addr_inc & len_mask);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        burst_d = burst_q;
        len_d   = len_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    addr_d  = s_axi_araddr[AXI_ADDR_WIDTH-1:BYTE_BITS];
                    id_d    = s_axi_arid;
                    burst_d = s_axi_arburst;
                    len_d   = s_axi_arlen;
                    rem_d   = s_axi_arlen;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (cmd_hs) begin
                    if (rem_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - 8'd1;
                        case (burst_q)
                            2'b00:   addr_d = addr_q;
                            2'b10:   addr_d = wrap_addr;
                            default: addr_d = addr_inc;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // arready is registered so it stays low through reset and rises one clock later.
        arready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            burst_q   <= 2'b00;
            len_q     <= 8'd0;
            rem_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            burst_q   <= burst_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
        end
    end

    assign s_axi_arready    = arready_q;
    assign sram_cmd_valid   = (state_q == BURST);
    assign sram_cmd_addr    = addr_q;
    assign sram_cmd_meta    = id_q;
    assign sram_cmd_last    = (state_q == BURST) && (rem_q == 8'd0);
    assign sram_cmd_wr_en   = 1'b0;
    assign sram_cmd_wr_data = '0;
    assign sram_cmd_wr_strb = '0;

    assign s_axi_rvalid       = sram_rd_resp_valid;
    assign s_axi_rid          = sram_rd_resp_meta;
    assign s_axi_rdata        = sram_rd_resp_data;
    assign s_axi_rresp        = 2'b00;
    assign s_axi_rlast        = sram_rd_resp_last;
    assign sram_rd_resp_ready = s_axi_rready;

    // arsize is ignored and the sub-word byte offset of araddr is dropped.
    assign unused_ok = ^{s_axi_arsize, s_axi_araddr};

endmodule
